// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: one BCD nibble per slot to a shared
// registered decoder, with blanking, per-digit blink and frame-start snapshot of the inputs.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [3:0]              number_data,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FR_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [FR_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_mask_q, snap_mask_d;
    logic [3:0]              number_data_q, number_data_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    slot_end_s;
    logic                    blank_end_s;
    logic                    slot_start_s;
    logic                    frame_start_s;
    logic                    wrap_s;
    logic [IDX_W-1:0]        next_idx_s;
    logic [3:0]              cur_nibble_s;
    logic                    show_lit_s;

    function automatic logic [3:0] nibble_at(input logic [4*NUM_DIGITS-1:0] vec,
                                             input logic [IDX_W-1:0]        idx);
        logic [3:0] nib;
        nib = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib = (idx == IDX_W'(k)) ? vec[4*k +: 4] : nib;
        end
        return nib;
    endfunction

    function automatic logic bit_at(input logic [NUM_DIGITS-1:0] vec,
                                    input logic [IDX_W-1:0]      idx);
        logic b;
        b = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            b = (idx == IDX_W'(k)) ? vec[k] : b;
        end
        return b;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] select_n(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] sel;
        sel = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel[k] = (idx == IDX_W'(k)) ? 1'b0 : 1'b1;
        end
        return sel;
    endfunction

    // Slot timing events shared by the FSM, counters and output logic
    always_comb begin
        slot_end_s    = (state_q == ST_SHOW)  && (slot_cnt_q == SLOT_LAST);
        blank_end_s   = (state_q == ST_BLANK) && (slot_cnt_q == BLANK_LAST);
        slot_start_s  = en && ((state_q == ST_IDLE) || slot_end_s);
        wrap_s        = en && slot_end_s && (digit_idx_q == LAST_IDX);
        if (state_q == ST_IDLE) begin
            next_idx_s = {IDX_W{1'b0}};
        end else if (digit_idx_q == LAST_IDX) begin
            next_idx_s = {IDX_W{1'b0}};
        end else begin
            next_idx_s = digit_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        frame_start_s = slot_start_s && (next_idx_s == {IDX_W{1'b0}});
        cur_nibble_s  = nibble_at(snap_digits_q, digit_idx_q);
        // Invalid codes would leave the decoder showing the previous digit
        show_lit_s    = (cur_nibble_s <= 4'd9) &&
                        !(bit_at(snap_mask_q, digit_idx_q) && blink_phase_q);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_BLANK;
                ST_BLANK: state_d = blank_end_s ? ST_SHOW : ST_BLANK;
                ST_SHOW:  state_d = slot_end_s ? ST_BLANK : ST_SHOW;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: registered number_data, digit_sel and frame_tick
    always_comb begin
        number_data_d = number_data_q;
        digit_sel_d   = '1;
        frame_tick_d  = 1'b0;
        if (!en) begin
            number_data_d = 4'd0;
        end else if (slot_start_s) begin
            number_data_d = frame_start_s ? digits_bcd[3:0]
                                          : nibble_at(snap_digits_q, next_idx_s);
            frame_tick_d  = frame_start_s;
        end else begin
            case (state_q)
                ST_BLANK: digit_sel_d = (blank_end_s && show_lit_s) ? select_n(digit_idx_q) : '1;
                ST_SHOW:  digit_sel_d = show_lit_s ? select_n(digit_idx_q) : '1;
                default:  digit_sel_d = '1;
            endcase
        end
    end

    // Slot counter, digit index, blink timing and frame snapshot
    always_comb begin
        slot_cnt_d    = slot_cnt_q;
        digit_idx_d   = digit_idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        snap_digits_d = snap_digits_q;
        snap_mask_d   = snap_mask_q;
        if (!en || slot_start_s || (state_q == ST_IDLE)) begin
            slot_cnt_d = {CNT_W{1'b0}};
        end else begin
            slot_cnt_d = slot_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (!en) begin
            digit_idx_d = {IDX_W{1'b0}};
        end else if (slot_start_s) begin
            digit_idx_d = next_idx_s;
        end else begin
            digit_idx_d = digit_idx_q;
        end
        if (wrap_s) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = {FR_W{1'b0}};
                blink_phase_d = !blink_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + {{(FR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        // Inputs are only sampled at frame start so a frame never tears
        if (frame_start_s) begin
            snap_digits_d = digits_bcd;
            snap_mask_d   = blink_mask;
        end else begin
            snap_digits_d = snap_digits_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= {CNT_W{1'b0}};
            digit_idx_q   <= {IDX_W{1'b0}};
            frame_cnt_q   <= {FR_W{1'b0}};
            blink_phase_q <= 1'b0;
            snap_digits_q <= {(4*NUM_DIGITS){1'b0}};
            snap_mask_q   <= {NUM_DIGITS{1'b0}};
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_digits_q <= snap_digits_d;
            snap_mask_q   <= snap_mask_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_data_q <= 4'd0;
            digit_sel_q   <= {NUM_DIGITS{1'b1}};
            frame_tick_q  <= 1'b0;
        end else begin
            number_data_q <= number_data_d;
            digit_sel_q   <= digit_sel_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign number_data = number_data_q;
    assign digit_sel   = digit_sel_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: per-cycle scoreboard against a time-based reference
// model, a table of whole-frame expectations, and hand sequences for corner cases.
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int S  = 8;
    localparam int B  = 2;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [15:0]   digits_bcd = 16'h0000;
    logic [3:0]    blink_mask = 4'h0;
    logic [3:0]    number_data;
    logic [3:0]    digit_sel;
    logic          frame_tick;

    int total = 0;
    int bad   = 0;

    display_scan_ctrl #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_bcd(digits_bcd),
        .blink_mask(blink_mask), .number_data(number_data),
        .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: position derived from elapsed cycles since the scan started
    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] nd;
        logic       tick;
    } exp_t;

    exp_t        sb_q[$];
    bit          m_active = 1'b0;
    int          m_t = 0;
    int          m_g = 0;
    logic [15:0] m_snap = 16'h0000;
    logic [3:0]  m_mask = 4'h0;

    always @(posedge clk) begin
        int         slot;
        int         pos;
        logic [3:0] nib;
        logic       lit;
        if (!rst_n) begin
            m_active = 1'b0;
            m_g      = 0;
        end else if (!en) begin
            m_active = 1'b0;
            sb_q.push_back('{4'hF, 4'h0, 1'b0});
        end else begin
            if (!m_active) begin
                m_active = 1'b1;
                m_t      = 0;
            end else begin
                m_t = m_t + 1;
                if (m_t == N * S) begin
                    m_t = 0;
                    m_g = m_g + 1;
                end
            end
            if (m_t == 0) begin
                m_snap = digits_bcd;
                m_mask = blink_mask;
            end
            slot = m_t / S;
            pos  = m_t % S;
            nib  = m_snap[slot*4 +: 4];
            lit  = (pos >= B) && (nib <= 4'd9) && !(m_mask[slot] && (((m_g / BF) % 2) == 1));
            sb_q.push_back('{lit ? ~(4'b0001 << slot) : 4'hF, nib, (m_t == 0)});
        end
    end

    always @(negedge rst_n) sb_q.delete();

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_sel",  {4'h0, digit_sel},   {4'h0, e.sel});
            check("sb_nd",   {4'h0, number_data}, {4'h0, e.nd});
            check("sb_tick", {7'h0, frame_tick},  {7'h0, e.tick});
        end
    end

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        check("tick_wait", {7'h0, ok}, 8'h01);
    endtask

    typedef struct packed {
        logic [15:0] digits;
        logic [15:0] nd_exp;
        logic [15:0] sel_exp;
    } vec_t;

    vec_t tbl[5];
    logic [3:0] blink_exp[6];

    initial begin
        int slot;
        int pos;
        int n;
        tbl[0] = '{16'h1234, 16'h1234, 16'h7BDE};
        tbl[1] = '{16'h5678, 16'h5678, 16'h7BDE};
        tbl[2] = '{16'h12A4, 16'h12A4, 16'h7BFE};
        tbl[3] = '{16'h9F09, 16'h9F09, 16'h7FDE};
        tbl[4] = '{16'h0000, 16'h0000, 16'h7BDE};
        blink_exp[0] = 4'hD; blink_exp[1] = 4'hD; blink_exp[2] = 4'hF;
        blink_exp[3] = 4'hF; blink_exp[4] = 4'hD; blink_exp[5] = 4'hD;

        // reset and idle
        repeat (3) @(negedge clk);
        check("rst_sel", {4'h0, digit_sel}, 8'h0F);
        check("rst_nd", {4'h0, number_data}, 8'h00);
        check("rst_tick", {7'h0, frame_tick}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_sel", {4'h0, digit_sel}, 8'h0F);
            check("idle_nd", {4'h0, number_data}, 8'h00);
            check("idle_tick", {7'h0, frame_tick}, 8'h00);
        end

        // table: one full frame per record
        en = 1'b1;
        for (int r = 0; r < 5; r++) begin
            digits_bcd = tbl[r].digits;
            wait_tick();
            for (int c = 0; c < N * S; c++) begin
                slot = c / S;
                pos  = c % S;
                check("tbl_nd", {4'h0, number_data}, {4'h0, tbl[r].nd_exp[slot*4 +: 4]});
                check("tbl_sel", {4'h0, digit_sel},
                      {4'h0, (pos < B) ? 4'hF : tbl[r].sel_exp[slot*4 +: 4]});
                check("tbl_tick", {7'h0, frame_tick}, {7'h0, (c == 0)});
                if (c < N * S - 1) @(negedge clk);
            end
        end

        // frame period
        wait_tick();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        check("tick_period", n[7:0], 8'd32);

        // snapshot: mid-frame change only lands at next frame
        digits_bcd = 16'h1234;
        wait_tick();
        repeat (16) @(negedge clk);
        digits_bcd = 16'h5678;
        repeat (3) @(negedge clk);
        check("snap_d2_nd", {4'h0, number_data}, 8'h02);
        check("snap_d2_sel", {4'h0, digit_sel}, 8'h0B);
        repeat (8) @(negedge clk);
        check("snap_d3_nd", {4'h0, number_data}, 8'h01);
        check("snap_d3_sel", {4'h0, digit_sel}, 8'h07);
        repeat (5) @(negedge clk);
        check("snap_new_tick", {7'h0, frame_tick}, 8'h01);
        check("snap_new_nd", {4'h0, number_data}, 8'h08);
        repeat (11) @(negedge clk);
        check("snap_new_d1", {4'h0, number_data}, 8'h07);

        // en drop at third SHOW cycle of digit 1, then resume
        wait_tick();
        repeat (12) @(negedge clk);
        check("drop_pre_sel", {4'h0, digit_sel}, 8'h0D);
        en = 1'b0;
        @(negedge clk);
        check("drop_sel", {4'h0, digit_sel}, 8'h0F);
        check("drop_nd", {4'h0, number_data}, 8'h00);
        repeat (3) @(negedge clk);
        check("drop_hold_tick", {7'h0, frame_tick}, 8'h00);
        en = 1'b1;
        @(negedge clk);
        check("resume_tick", {7'h0, frame_tick}, 8'h01);
        check("resume_nd", {4'h0, number_data}, 8'h08);
        check("resume_sel", {4'h0, digit_sel}, 8'h0F);

        // asynchronous reset mid-SHOW
        repeat (3) @(negedge clk);
        check("arst_pre_sel", {4'h0, digit_sel}, 8'h0E);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", {4'h0, digit_sel}, 8'h0F);
        check("arst_nd", {4'h0, number_data}, 8'h00);
        check("arst_tick", {7'h0, frame_tick}, 8'h00);

        // blink on digit 1 from a fresh reset
        digits_bcd = 16'h1234;
        blink_mask = 4'b0010;
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 6; f++) begin
            wait_tick();
            repeat (4) @(negedge clk);
            check("blink_d0", {4'h0, digit_sel}, 8'h0E);
            repeat (8) @(negedge clk);
            check("blink_d1", {4'h0, digit_sel}, {4'h0, blink_exp[f]});
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
